// File: rtl/pitch_glide_engine_if.sv
// pitch_glide_engine_if: note, register, query and result signals of the pitch glide engine
//   master drives note_on/key_adr/key_val, pitch_val, register bus (data/adr/write/osc_sel/com_sel)
//   and queries (req/req_voice/req_osc); slave returns out_valid, osc_key and busy.
interface pitch_glide_engine_if #(
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2,
  parameter int FRAC    = 12
);
  logic               note_on;
  logic [V_WIDTH-1:0] key_adr;
  logic [7:0]         key_val;
  logic [13:0]        pitch_val;
  logic [7:0]         data;
  logic [6:0]         adr;
  logic               write;
  logic               osc_sel;
  logic               com_sel;
  logic               req;
  logic [V_WIDTH-1:0] req_voice;
  logic [O_WIDTH-1:0] req_osc;
  logic               out_valid;
  logic [8+FRAC:0]    osc_key;
  logic               busy;
  modport master (
    output note_on, key_adr, key_val, pitch_val, data, adr, write, osc_sel, com_sel,
           req, req_voice, req_osc,
    input  out_valid, osc_key, busy
  );
  modport slave (
    input  note_on, key_adr, key_val, pitch_val, data, adr, write, osc_sel, com_sel,
           req, req_voice, req_osc,
    output out_valid, osc_key, busy
  );
endinterface

// File: rtl/pitch_glide_engine.sv
// pitch_glide_engine: per-voice portamento sweeper plus 2-stage fractional key query pipeline
//   sCLK_XVXENVS clock, iRST_N async active-low reset, bus slave modport carries all other ports.
//   Optional vibrato term enabled by defining PITCH_VIBRATO_EN.
module pitch_glide_engine #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3,
  parameter int V_OSC   = 4,
  parameter int O_WIDTH = 2,
  parameter int FRAC    = 12
) (
  input logic sCLK_XVXENVS,
  input logic iRST_N,
  pitch_glide_engine_if.slave bus
);
  localparam int KW = 8 + FRAC;
  localparam int KO = 9 + FRAC;
  localparam logic signed [31:0] SMAX = (32'sd512 <<< FRAC) - 32'sd1;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q, state_d;
  logic [V_WIDTH-1:0] idx_q, idx_d;
  logic [KW-1:0] cur_q [VOICES], cur_d [VOICES];
  logic [7:0] tgt_q [VOICES], tgt_d [VOICES];
  logic [7:0] ct_q [V_OSC], ct_d [V_OSC], ft_q [V_OSC], ft_d [V_OSC];
  logic [7:0] pbr_q, pbr_d, gstep_q, gstep_d, gdiv_q, gdiv_d;
  logic [15:0] presc_q, presc_d;
  logic v1_q, v1_d, out_valid_q, out_valid_d;
  logic signed [31:0] s1_q, s1_d;
  logic [KO-1:0] key_q, key_d;
  logic tick, wr_com;
  logic [KW-1:0] tf, step, cur_i, nxt;
  logic signed [31:0] curv, ctv, ftv, pw, pr, pbv, sum, vib;
`ifdef PITCH_VIBRATO_EN
  logic [7:0] vdep_q, vdep_d, vrate_q, vrate_d;
  logic [15:0] ph_q, ph_d;
  logic [6:0] tri_m;
  logic signed [31:0] tri_v, dep;
  always_comb begin
    vdep_d  = wr_com && bus.adr == 7'd3 ? bus.data : vdep_q;
    vrate_d = wr_com && bus.adr == 7'd4 ? bus.data : vrate_q;
    ph_d    = ph_q + 16'(vrate_q);
    // fold the phase into a symmetric triangle spanning -127..127
    tri_m   = ph_q[15] ? ~ph_q[14:8] : ph_q[14:8];
    tri_v   = 32'(tri_m) * 32'sd2 - 32'sd127;
    dep     = 32'(vdep_q);
    vib     = (tri_v * dep) >>> (21 - FRAC);
  end
  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N)
    if (!iRST_N) begin
      vdep_q  <= '0;
      vrate_q <= '0;
      ph_q    <= '0;
    end else begin
      vdep_q  <= vdep_d;
      vrate_q <= vrate_d;
      ph_q    <= ph_d;
    end
`else
  assign vib = '0;
`endif
  always_comb begin
    wr_com  = bus.write && bus.com_sel && !bus.osc_sel;
    pbr_d   = wr_com && bus.adr == 7'd0 ? bus.data : pbr_q;
    gstep_d = wr_com && bus.adr == 7'd1 ? bus.data : gstep_q;
    gdiv_d  = wr_com && bus.adr == 7'd2 ? bus.data : gdiv_q;
    for (int o = 0; o < V_OSC; o++) begin
      ct_d[o] = bus.write && bus.osc_sel && bus.adr == 7'(o * 16 + 8) ? bus.data : ct_q[o];
      ft_d[o] = bus.write && bus.osc_sel && bus.adr == 7'(o * 16 + 9) ? bus.data : ft_q[o];
    end
    tick    = presc_q == 16'd0;
    presc_d = tick ? {gdiv_q, 8'hFF} : presc_q - 16'd1;
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == IDLE) begin
      if (tick && gstep_q != 8'd0) begin
        state_d = SWEEP;
        idx_d   = '0;
      end
    end else begin
      idx_d = V_WIDTH'(idx_q + 1'b1);
      if (idx_q == V_WIDTH'(VOICES - 1)) state_d = IDLE;
    end
    // the step snaps to the target when within one step, so it never overshoots
    tf    = {tgt_q[idx_q], {FRAC{1'b0}}};
    step  = KW'(gstep_q) << (FRAC - 8);
    cur_i = cur_q[idx_q];
    nxt   = cur_i < tf ? (tf - cur_i <= step ? tf : cur_i + step)
                       : (cur_i - tf <= step ? tf : cur_i - step);
    for (int v = 0; v < VOICES; v++) begin
      cur_d[v] = cur_q[v];
      tgt_d[v] = tgt_q[v];
    end
    if (state_q == SWEEP) cur_d[idx_q] = nxt;
    // note_on overrides any sweep update to the same voice this cycle
    if (bus.note_on) begin
      tgt_d[bus.key_adr] = bus.key_val;
      cur_d[bus.key_adr] = gstep_q == 8'd0 ? {bus.key_val, {FRAC{1'b0}}} : cur_q[bus.key_adr];
    end
    curv = 32'(cur_q[bus.req_voice]);
    ctv  = 32'(ct_q[bus.req_osc]) - 32'd64;
    ftv  = 32'(ft_q[bus.req_osc]) - 32'd64;
    s1_d = (32'sd128 <<< FRAC) + curv + (ctv <<< FRAC) + (ftv <<< (FRAC - 6));
    v1_d = bus.req;
    pw   = 32'(bus.pitch_val) - 32'd8192;
    pr   = 32'(pbr_q);
    pbv  = (pw * pr) >>> (13 - FRAC);
    sum  = s1_q + pbv + vib;
    key_d = !v1_q ? key_q : sum < 0 ? '0 : sum > SMAX ? KO'(SMAX) : KO'(sum);
    out_valid_d = v1_q;
  end
  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N)
    if (!iRST_N) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      for (int v = 0; v < VOICES; v++) begin
        cur_q[v] <= '0;
        tgt_q[v] <= '0;
      end
      for (int o = 0; o < V_OSC; o++) begin
        ct_q[o] <= 8'h40;
        ft_q[o] <= 8'h40;
      end
      pbr_q       <= 8'd3;
      gstep_q     <= '0;
      gdiv_q      <= '0;
      presc_q     <= 16'h00FF;
      v1_q        <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      key_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      ct_q        <= ct_d;
      ft_q        <= ft_d;
      pbr_q       <= pbr_d;
      gstep_q     <= gstep_d;
      gdiv_q      <= gdiv_d;
      presc_q     <= presc_d;
      v1_q        <= v1_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      key_q       <= key_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.osc_key   = key_q;
  assign bus.busy      = state_q == SWEEP;
endmodule

// File: tb/tb_pitch_glide_engine.sv
// tb_pitch_glide_engine: directed self-checking bench for pitch_glide_engine (FRAC=12)
module tb_pitch_glide_engine;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  pitch_glide_engine_if #(.V_WIDTH(3), .O_WIDTH(2), .FRAC(12)) bus();
  pitch_glide_engine #(.VOICES(8), .V_WIDTH(3), .V_OSC(4), .O_WIDTH(2), .FRAC(12)) dut (
    .sCLK_XVXENVS(clk),
    .iRST_N(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic osc, input logic [6:0] a, input logic [7:0] d);
    bus.write = 1'b1;
    bus.osc_sel = osc;
    bus.com_sel = !osc;
    bus.adr = a;
    bus.data = d;
    cyc();
    bus.write = 1'b0;
    bus.osc_sel = 1'b0;
    bus.com_sel = 1'b0;
  endtask
  task automatic note(input int v, input int k);
    bus.note_on = 1'b1;
    bus.key_adr = v[2:0];
    bus.key_val = k[7:0];
    cyc();
    bus.note_on = 1'b0;
  endtask
  task automatic query(input int v, input int o, input logic [31:0] exp, input string tag);
    bus.req = 1'b1;
    bus.req_voice = v[2:0];
    bus.req_osc = o[1:0];
    cyc();
    bus.req = 1'b0;
    check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    cyc();
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check(tag, 32'(bus.osc_key), exp);
  endtask
  task automatic wait_busy(input logic lvl);
    for (int n = 0; n < 600 && bus.busy !== lvl; n++) cyc();
    check("wait_busy", 32'(bus.busy), 32'(lvl));
  endtask
  initial begin
    int n;
    rst_n = 1'b0;
    bus.note_on = 1'b0;
    bus.key_adr = '0;
    bus.key_val = '0;
    bus.pitch_val = 14'h2000;
    bus.data = '0;
    bus.adr = '0;
    bus.write = 1'b0;
    bus.osc_sel = 1'b0;
    bus.com_sel = 1'b0;
    bus.req = 1'b0;
    bus.req_voice = '0;
    bus.req_osc = '0;
    cyc();
    cyc();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_key", 32'(bus.osc_key), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    cyc();
    query(0, 0, 32'h80000, "base_v0");
    note(2, 60);
    query(2, 0, 32'hBC000, "note_v2");
    bus.req = 1'b1;
    bus.req_voice = 3'd2;
    cyc();
    bus.req_voice = 3'd0;
    cyc();
    bus.req = 1'b0;
    check("b2b_a_vld", 32'(bus.out_valid), 32'd1);
    check("b2b_a", 32'(bus.osc_key), 32'hBC000);
    cyc();
    check("b2b_b_vld", 32'(bus.out_valid), 32'd1);
    check("b2b_b", 32'(bus.osc_key), 32'h80000);
    wr(1'b1, 7'd40, 8'h41);
    query(0, 2, 32'h81000, "osc2_ct");
    wr(1'b1, 7'd41, 8'h42);
    query(0, 2, 32'h81080, "osc2_ft");
    wr(1'b1, 7'd10, 8'h00);
    query(0, 0, 32'h80000, "ign_adr");
    wr(1'b0, 7'd0, 8'd2);
    bus.pitch_val = 14'h3FFF;
    query(0, 0, 32'h80000 + 32'd8191, "pb_up");
    bus.pitch_val = 14'h0000;
    query(0, 0, 32'h80000 - 32'd8192, "pb_dn");
    wr(1'b1, 7'd8, 8'h00);
    wr(1'b1, 7'd9, 8'h00);
    wr(1'b0, 7'd0, 8'hFF);
    query(0, 0, 32'h0, "sat_lo");
    wr(1'b1, 7'd8, 8'h7F);
    note(4, 255);
    bus.pitch_val = 14'h3FFF;
    query(4, 0, 32'h1FFFFF, "sat_hi");
    wr(1'b1, 7'd8, 8'h40);
    wr(1'b1, 7'd9, 8'h40);
    wr(1'b0, 7'd0, 8'd3);
    bus.pitch_val = 14'h2000;
    wr(1'b0, 7'd1, 8'h10);
    wait_busy(1'b1);
    wait_busy(1'b0);
    note(1, 12);
    wait_busy(1'b1);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      cyc();
    end
    check("busy_len", 32'(n), 32'd8);
    query(1, 0, 32'h80100, "glide_1");
    for (int p = 0; p < 191; p++) begin
      wait_busy(1'b1);
      wait_busy(1'b0);
    end
    query(1, 0, 32'h8C000, "glide_end");
    wait_busy(1'b1);
    wait_busy(1'b0);
    query(1, 0, 32'h8C000, "glide_hold");
    note(1, 11);
    wait_busy(1'b1);
    wait_busy(1'b0);
    query(1, 0, 32'h8BF00, "glide_down");
    note(3, 8);
    wait_busy(1'b1);
    cyc();
    cyc();
    cyc();
    note(3, 20);
    wait_busy(1'b0);
    query(3, 0, 32'h80000, "coinc_skip");
    wait_busy(1'b1);
    wait_busy(1'b0);
    query(3, 0, 32'h80100, "coinc_next");
    wait_busy(1'b1);
    cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    check("mid_rst_key", 32'(bus.osc_key), 32'd0);
    cyc();
    rst_n = 1'b1;
    bus.pitch_val = 14'h3FFF;
    query(1, 0, 32'h82FFE, "rst_cur1_pb3");
    bus.pitch_val = 14'h2000;
    query(3, 0, 32'h80000, "rst_cur3");
    query(2, 0, 32'h80000, "rst_cur2");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
